// File: rtl/prod_accum_pkg.sv
// Shared types and sizing helpers for the prod_accum product accumulator.
package prod_accum_pkg;

    localparam int unsigned PROD_W = 10;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Term counter width for a batch of n products; at least one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// ACC_W-bit adder with a zero-extended product addend, carry out and
// optional saturation (enabled by defining PROD_ACCUM_SAT_EN).
module sat_add
    import prod_accum_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] sum_ext;

    // Full-width add so the carry out of bit ACC_W-1 is visible.
    always_comb begin
        sum_ext = {1'b0, acc_in} + (ACC_W+1)'(addend);
        carry   = sum_ext[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
        sum     = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        sum     = sum_ext[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accum.sv
// Streaming batch accumulator for 10-bit multiplier products.
// Sums NTERMS accepted products and holds the registered result until taken.
// Optional saturation: define PROD_ACCUM_SAT_EN (handled inside sat_add).
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned NTERMS = 8,
    parameter int unsigned ACC_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int unsigned CNT_W = cnt_w(NTERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NTERMS - 1);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               accept;
    logic               complete;

    // Accumulate path; saturation policy lives in the adder.
    sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_in (acc),
        .addend (in_prod),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    // Handshake decode: a clear always blocks the input for that cycle.
    always_comb begin
        in_ready = !in_clear && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        complete = accept && (cnt == LAST);
    end

    assign out_valid = (state == HOLD);

    // Partial-batch accumulator, term count and sticky carry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (in_clear || complete) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= add_sum;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | add_carry;
        end
    end

    // Output FSM: ACCUM while collecting, HOLD while a result is presented.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ACCUM;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (complete) begin
                out_sum <= add_sum;
                out_ovf <= ovf | add_carry;
            end
            case (state)
                ACCUM: if (complete) state <= HOLD;
                HOLD:  if (out_ready && !complete) state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum (NTERMS=8, ACC_W=12) with a batch-level
// reference model and directed scenarios.
module tb_prod_accum;

    localparam int NTERMS = 8;
    localparam int ACC_W  = 12;
    localparam int MOD    = 1 << ACC_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [9:0]        in_prod = 10'd0;
    logic              in_clear = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;

    // Model state: presented result plus running integer total of the batch.
    logic m_ov   = 1'b0;
    int   m_sum  = 0;
    logic m_ovf  = 1'b0;
    int   m_total = 0;
    int   m_n    = 0;

    prod_accum #(.NTERMS(NTERMS), .ACC_W(ACC_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_clear  (in_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clock = ~clock;

    // Reference model: exact integer batch total, reduced only at completion.
    always @(posedge clock or posedge reset) begin : mdl
        logic rdy;
        logic done;
        int   t;
        int   n;
        int   s;
        logic o;
        if (reset) begin
            m_ov    <= 1'b0;
            m_sum   <= 0;
            m_ovf   <= 1'b0;
            m_total <= 0;
            m_n     <= 0;
        end else begin
            rdy  = !in_clear && (!m_ov || out_ready);
            done = 1'b0;
            t    = m_total;
            n    = m_n;
            s    = m_sum;
            o    = m_ovf;
            if (in_clear) begin
                t = 0;
                n = 0;
            end else if (in_valid && rdy) begin
                t = t + int'(in_prod);
                n = n + 1;
                if (n == NTERMS) begin
                    done = 1'b1;
                    o    = (t >= MOD);
`ifdef PROD_ACCUM_SAT_EN
                    s    = (t >= MOD) ? MOD - 1 : t;
`else
                    s    = t % MOD;
`endif
                    t    = 0;
                    n    = 0;
                end
            end
            m_total <= t;
            m_n     <= n;
            m_sum   <= s;
            m_ovf   <= o;
            if (done)
                m_ov <= 1'b1;
            else if (m_ov && out_ready)
                m_ov <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, then compare the DUT against the model mid-cycle.
    task automatic drive(input logic v, input logic [9:0] p, input logic clr, input logic rdy);
        @(posedge clock);
        #1;
        in_valid  = v;
        in_prod   = p;
        in_clear  = clr;
        out_ready = rdy;
        @(negedge clock);
        if (!reset) begin
            check("model_in_ready", int'(in_ready), int'(!in_clear && (!m_ov || out_ready)));
            check("model_out_valid", int'(out_valid), int'(m_ov));
            if (m_ov) begin
                check("model_out_sum", int'(out_sum), m_sum);
                check("model_out_ovf", int'(out_ovf), int'(m_ovf));
            end
            if (out_valid) vcnt++;
        end
    endtask

    // Idle with out_ready high until a result appears, then pin it to literals.
    task automatic wait_result(input string name, input int exp_sum, input logic exp_ovf);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b0, 10'd0, 1'b0, 1'b1);
            if (out_valid) found = 1;
        end
        check({name, "_seen"}, int'(found), 1);
        if (found) begin
            check({name, "_sum"}, int'(out_sum), exp_sum);
            check({name, "_ovf"}, int'(out_ovf), int'(exp_ovf));
            check({name, "_model_sum"}, m_sum, exp_sum);
        end
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_ovf", int'(out_ovf), 0);
        check("rst_in_ready", int'(in_ready), 1);
        #14 reset = 1'b0;

        // Basic batch 1..8
        vcnt = 0;
        for (int i = 1; i <= 8; i++) drive(1'b1, 10'(i), 1'b0, 1'b1);
        wait_result("basic", 36, 1'b0);
        repeat (3) drive(1'b0, 10'd0, 1'b0, 1'b1);
        check("basic_valid_cycles", vcnt, 1);

        // Overflow: 8 x 961 = 7688
        for (int i = 0; i < 8; i++) drive(1'b1, 10'd961, 1'b0, 1'b1);
`ifdef PROD_ACCUM_SAT_EN
        wait_result("ovf", 4095, 1'b1);
`else
        wait_result("ovf", 3592, 1'b1);
`endif

        // Backpressure: 8 x 5, stall 5 cycles with a term waiting
        for (int i = 0; i < 8; i++) drive(1'b1, 10'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10'd5, 1'b0, 1'b0);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_sum", int'(out_sum), 40);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        drive(1'b1, 10'd5, 1'b0, 1'b1);
        check("bp_release_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 7; i++) drive(1'b1, 10'd5, 1'b0, 1'b1);
        wait_result("bp_next", 40, 1'b0);

        // Clear: 3 x 100, clear with a 7 presented, then 8 x 2
        for (int i = 0; i < 3; i++) drive(1'b1, 10'd100, 1'b0, 1'b1);
        drive(1'b1, 10'd7, 1'b1, 1'b1);
        check("clr_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 10'd2, 1'b0, 1'b1);
        wait_result("clear", 16, 1'b0);

        // Reset mid-batch: asynchronous, checked before any clock edge
        for (int i = 0; i < 5; i++) drive(1'b1, 10'd10, 1'b0, 1'b1);
        drive(1'b0, 10'd0, 1'b0, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_sum", int'(out_sum), 0);
        check("mid_rst_out_ovf", int'(out_ovf), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(1'b1, 10'd10, 1'b0, 1'b1);
        wait_result("post_rst", 80, 1'b0);

        // Gappy input: 1..8 with a bubble after each term
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 10'(i), 1'b0, 1'b1);
            drive(1'b0, 10'd0, 1'b0, 1'b1);
            if (i < 8) check("gappy_no_early_valid", int'(out_valid), 0);
        end
        check("gappy_valid_after_last", int'(out_valid), 1);
        check("gappy_sum", int'(out_sum), 36);
        repeat (2) drive(1'b0, 10'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
